// File: rtl/noekeon_iter_ctrl.sv
// Iterative Noekeon sequencer: holds state/key, walks the round-constant schedule through
// ROUNDS full rounds plus one last round on external datapaths, then hands off the result.
module noekeon_iter_ctrl #(
  parameter int unsigned ROUNDS      = 16,
  parameter logic [7:0]  RC_ENC_INIT = 8'h80,
  parameter logic [7:0]  RC_DEC_INIT = 8'hD4
) (
  input  logic         inClk,
  input  logic         inRstN,

  input  logic         inStart,
  input  logic         inDecipher,
  input  logic [127:0] inData,
  input  logic [127:0] inKey,
  output logic         outBusy,

  output logic [127:0] outRoundData,
  output logic [127:0] outRoundKey,
  output logic [7:0]   outRoundconst,
  output logic         outRoundDecipher,
  output logic         outRoundLast,
  input  logic [127:0] inRoundResult,

  output logic         outValid,
  output logic [127:0] outData,
  input  logic         inReady
);

  localparam int unsigned CntW = $clog2(ROUNDS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ROUNDS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      fsm_q, fsm_d;
  logic [127:0]    state_q, state_d;
  logic [127:0]    key_q, key_d;
  logic [7:0]      rc_q, rc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            last_round;

  // Forward LFSR step (multiply by x in GF(2^8) mod 0x11B).
  function automatic logic [7:0] rc_step_enc(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  endfunction

  // Exact inverse of rc_step_enc, so decryption walks the schedule backwards.
  function automatic logic [7:0] rc_step_dec(input logic [7:0] rc);
    return rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
  endfunction

  assign last_round = (fsm_q == StRun) && (cnt_q == CntLast);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (fsm_q)
      StIdle: begin
        if (inStart) begin
          state_d = inData;
          key_d   = inKey;
          dir_d   = inDecipher;
          rc_d    = inDecipher ? RC_DEC_INIT : RC_ENC_INIT;
          cnt_d   = '0;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        state_d = inRoundResult;
        rc_d    = dir_q ? rc_step_dec(rc_q) : rc_step_enc(rc_q);
        if (last_round) begin
          cnt_d = '0;
          fsm_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (inReady) begin
          fsm_d = StIdle;
        end
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign outBusy          = (fsm_q == StRun) || (fsm_q == StDone);
  assign outRoundData     = state_q;
  assign outRoundKey      = key_q;
  assign outRoundconst    = (fsm_q == StRun) ? rc_q : 8'h00;
  assign outRoundDecipher = dir_q;
  assign outRoundLast     = last_round;
  assign outValid         = (fsm_q == StDone);
  assign outData          = (fsm_q == StDone) ? state_q : '0;

endmodule

// File: tb/tb_noekeon_iter_ctrl.sv
// Bench for noekeon_iter_ctrl: supplies a behavioural Noekeon round datapath, keeps a
// transaction-level model of the expected outputs and compares against it every cycle.
module tb_noekeon_iter_ctrl;

  localparam int unsigned ROUNDS = 16;

  logic         inClk;
  logic         inRstN;
  logic         inStart;
  logic         inDecipher;
  logic [127:0] inData;
  logic [127:0] inKey;
  logic         outBusy;
  logic [127:0] outRoundData;
  logic [127:0] outRoundKey;
  logic [7:0]   outRoundconst;
  logic         outRoundDecipher;
  logic         outRoundLast;
  logic [127:0] inRoundResult;
  logic         outValid;
  logic [127:0] outData;
  logic         inReady;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit chk_en = 0;

  logic [7:0] rc_tab [0:ROUNDS];
  logic [7:0] rc_lit [0:16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                                8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A,
                                8'hD4};

  noekeon_iter_ctrl #(
    .ROUNDS      (ROUNDS),
    .RC_ENC_INIT (8'h80),
    .RC_DEC_INIT (8'hD4)
  ) dut (
    .inClk            (inClk),
    .inRstN           (inRstN),
    .inStart          (inStart),
    .inDecipher       (inDecipher),
    .inData           (inData),
    .inKey            (inKey),
    .outBusy          (outBusy),
    .outRoundData     (outRoundData),
    .outRoundKey      (outRoundKey),
    .outRoundconst    (outRoundconst),
    .outRoundDecipher (outRoundDecipher),
    .outRoundLast     (outRoundLast),
    .inRoundResult    (inRoundResult),
    .outValid         (outValid),
    .outData          (outData),
    .inReady          (inReady)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // ---------------- Noekeon primitives (reference datapath) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] theta(input logic [127:0] k, input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    t  = a0 ^ a2;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[127:96];
    a1 = a1 ^ k[95:64];
    a2 = a2 ^ k[63:32];
    a3 = a3 ^ k[31:0];
    t  = a1 ^ a3;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {s[127:96], rotl(s[95:64], 1), rotl(s[63:32], 5), rotl(s[31:0], 2)};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    return {s[127:96], rotl(s[95:64], 31), rotl(s[63:32], 27), rotl(s[31:0], 30)};
  endfunction

  function automatic logic [127:0] nk_round(input logic [127:0] s, input logic [127:0] k,
                                            input logic [7:0] rc, input logic dec,
                                            input logic last);
    logic [127:0] t;
    t = s;
    if (!dec) begin
      t[103:96] = t[103:96] ^ rc;
      t = theta(k, t);
    end else begin
      t = theta(k, t);
      t[103:96] = t[103:96] ^ rc;
    end
    if (!last) t = pi2(gamma(pi1(t)));
    return t;
  endfunction

  // Encryption uses RC[0..ROUNDS] in order; decryption uses the same table reversed.
  function automatic logic [7:0] rc_at(input logic dec, input int i);
    return dec ? rc_tab[ROUNDS - i] : rc_tab[i];
  endfunction

  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k,
                                          input logic dec);
    logic [127:0] s;
    s = d;
    for (int i = 0; i <= ROUNDS; i++) s = nk_round(s, k, rc_at(dec, i), dec, i == ROUNDS);
    return s;
  endfunction

  assign inRoundResult = nk_round(outRoundData, outRoundKey, outRoundconst, outRoundDecipher,
                                  outRoundLast);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_k: index of the round being computed (-1 when not computing).
  int           m_k     = -1;
  logic         m_valid = 1'b0;
  logic         m_dec   = 1'b0;
  logic [127:0] m_data  = '0;
  logic [127:0] m_key   = '0;
  logic [127:0] m_res   = '0;

  always @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      m_k     <= -1;
      m_valid <= 1'b0;
      m_dec   <= 1'b0;
      m_data  <= '0;
      m_key   <= '0;
      m_res   <= '0;
    end else if (m_valid) begin
      if (inReady) m_valid <= 1'b0;
    end else if (m_k < 0) begin
      if (inStart) begin
        m_k    <= 0;
        m_dec  <= inDecipher;
        m_data <= inData;
        m_key  <= inKey;
        m_res  <= cipher(inData, inKey, inDecipher);
      end
    end else if (m_k == ROUNDS) begin
      m_k     <= -1;
      m_valid <= 1'b1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge inClk) begin
    if (chk_en) begin
      check("status{busy,valid,last}", 128'({outBusy, outValid, outRoundLast}),
            128'({m_valid || (m_k >= 0), m_valid, m_k == ROUNDS}));
      check("roundconst", 128'(outRoundconst), 128'((m_k >= 0) ? rc_at(m_dec, m_k) : 8'h00));
      check("outdata", outData, m_valid ? m_res : 128'd0);
      if (m_k >= 0) begin
        check("roundkey", outRoundKey, m_key);
        check("rounddir", 128'(outRoundDecipher), 128'(m_dec));
      end
      if (m_k == 0) check("roundin", outRoundData, m_data);
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: stable inputs; 1: extra start pulse in RUN cycle 5; 2: scramble inputs every cycle.
  task automatic do_op(input logic [127:0] d, input logic [127:0] k, input logic dec,
                       input int hold, input int mode, output logic [127:0] res);
    int n;
    inData     = d;
    inKey      = k;
    inDecipher = dec;
    inStart    = 1'b1;
    @(posedge inClk); #1;
    inStart = 1'b0;
    n = 0;
    while (!outValid && n < 100) begin
      if (mode == 1) begin
        inStart = (n == 5);
        if (n == 5) inData = ~d;
      end else if (mode == 2) begin
        inData     = {$urandom, $urandom, $urandom, $urandom};
        inKey      = {$urandom, $urandom, $urandom, $urandom};
        inDecipher = 1'($urandom);
        inReady    = 1'($urandom);
      end
      @(posedge inClk); #1;
      n++;
    end
    inStart = 1'b0;
    inReady = 1'b0;
    check("latency", 128'(n), 128'(ROUNDS + 1));
    check("result", outData, cipher(d, k, dec));
    res = outData;
    repeat (hold) begin
      @(posedge inClk); #1;
    end
    inReady = 1'b1;
    @(posedge inClk); #1;
    inReady = 1'b0;
  endtask

  logic [127:0] ct0, res, ctx;
  logic [127:0] pt_x = 128'h0123456789ABCDEF_FEDCBA9876543210;
  logic [127:0] key_x = 128'hB1656851699E29FA_24B70148503D2DFC;

  initial begin
    logic [7:0] r;
    r = 8'h80;
    for (int i = 0; i <= ROUNDS; i++) begin
      rc_tab[i] = r;
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    end
    for (int i = 0; i <= 16; i++) check("rc_table", 128'(rc_tab[i]), 128'(rc_lit[i]));
    ct0 = cipher('0, '0, 1'b0);
    check("model_roundtrip", cipher(cipher(pt_x, key_x, 1'b0), theta('0, key_x), 1'b1), pt_x);

    inRstN = 1'b0; inStart = 1'b0; inDecipher = 1'b0; inReady = 1'b0;
    inData = '0; inKey = '0;
    repeat (3) @(posedge inClk);
    #1;
    check("reset_status", 128'({outBusy, outValid, outRoundLast}), 128'd0);
    check("reset_rc", 128'(outRoundconst), 128'd0);
    check("reset_data", outData, 128'd0);
    check("reset_state", outRoundData, 128'd0);
    inRstN = 1'b1;
    chk_en = 1;
    @(posedge inClk); #1;

    // encrypt zeros with 5-cycle backpressure, then decrypt back-to-back
    do_op('0, '0, 1'b0, 5, 0, res);
    do_op(ct0, '0, 1'b1, 0, 0, res);
    check("decrypt_to_zero", res, 128'd0);

    do_op(pt_x, key_x, 1'b0, 0, 0, ctx);
    do_op(ctx, theta('0, key_x), 1'b1, 0, 0, res);
    check("decrypt_nonzero_key", res, pt_x);

    do_op(pt_x, key_x, 1'b0, 2, 1, res);
    check("ignored_start", res, ctx);
    do_op(pt_x, key_x, 1'b0, 0, 2, res);
    check("scrambled_inputs", res, ctx);

    // asynchronous abort during RUN cycle 8
    inData = pt_x; inKey = key_x; inDecipher = 1'b0; inStart = 1'b1;
    @(posedge inClk); #1;
    inStart = 1'b0;
    repeat (8) begin
      @(posedge inClk); #1;
    end
    #2 inRstN = 1'b0;
    #1;
    check("abort_status", 128'({outBusy, outValid, outRoundLast}), 128'd0);
    check("abort_rc", 128'(outRoundconst), 128'd0);
    check("abort_data", outData, 128'd0);
    check("abort_state", outRoundData, 128'd0);
    check("abort_key", outRoundKey, 128'd0);
    @(posedge inClk); #1;
    inRstN = 1'b1;
    @(posedge inClk); #1;
    do_op('0, '0, 1'b0, 1, 0, res);
    check("after_abort", res, ct0);

    repeat (3) @(posedge inClk);
    chk_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
